// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared constants and state type for the bit-serial adder
//
// Purpose: default operand width and the controller state encoding shared by
//          serial_adder and its interface.
// Ports:   none (package).
package serial_adder_pkg;

   localparam int DEF_WIDTH = 8;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   // 2'd3 is never entered on purpose; the controller treats it as a fault
   // and falls back to idle.
   typedef enum logic [1:0] {
      ST_IDLE  = S_IDLE,
      ST_SHIFT = S_SHIFT,
      ST_DONE  = S_DONE,
      ST_BAD   = 2'd3
   } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - request/result bundle between a requester and serial_adder
//
// Purpose: groups the operand request and the registered result signals.
// Signals: Start/A/B/Cin driven by the master (requester);
//          Busy/Done/Sum/Cout driven by the slave (serial_adder).
// Modports: master - requester side; slave - adder side.
interface serial_adder_if
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);

   logic             Start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] Sum;
   logic             Cout;

   modport master (
      output Start, A, B, Cin,
      input  Busy, Done, Sum, Cout
   );

   modport slave (
      input  Start, A, B, Cin,
      output Busy, Done, Sum, Cout
   );

endinterface

// File: rtl/serial_adder_full_adder.sv
// rtl/serial_adder_full_adder.sv - single-bit full adder used as the serial datapath
//
// Purpose: one-bit A + B + Cin.
// Ports:   A, B, Cin in (1 bit each); Sum, Cout out (1 bit each).
module FullAdder (
   input  logic A,
   input  logic B,
   input  logic Cin,
   output logic Sum,
   output logic Cout
);

   assign Sum  = A ^ B ^ Cin;
   assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial unsigned adder, one operand bit per clock
//
// Purpose: computes {Cout,Sum} = A + B + Cin over WIDTH bits using one
//          FullAdder, a carry flip-flop, operand shift registers and a
//          three-state controller.
// Ports:   Clk   in  - rising-edge clock
//          Reset in  - synchronous, active-high reset
//          bus   slave modport of serial_adder_if:
//                Start/A/B/Cin in  - request, captured when accepted in idle
//                Busy          out - high whenever not idle
//                Done          out - one-cycle pulse, result valid
//                Sum/Cout      out - registered result, held until next completion
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic          Clk,
   input  logic          Reset,
   serial_adder_if.slave bus
);

   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] sum_sr;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic             fa_sum;
   logic             fa_cout;
   logic [WIDTH-1:0] sum_next;

   FullAdder u_fa (
      .A    (a_sr[0]),
      .B    (b_sr[0]),
      .Cin  (carry),
      .Sum  (fa_sum),
      .Cout (fa_cout)
   );

   // New sum bit enters at the MSB; after WIDTH shifts bit 0 of the result
   // has arrived at the LSB.
   assign sum_next = {fa_sum, {(WIDTH-1){1'b0}}} | (sum_sr >> 1);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state    <= ST_IDLE;
         a_sr     <= '0;
         b_sr     <= '0;
         sum_sr   <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         bus.Busy <= 1'b0;
         bus.Done <= 1'b0;
         bus.Sum  <= '0;
         bus.Cout <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               bus.Done <= 1'b0;
               if (bus.Start) begin
                  a_sr     <= bus.A;
                  b_sr     <= bus.B;
                  carry    <= bus.Cin;
                  sum_sr   <= '0;
                  cnt      <= '0;
                  bus.Busy <= 1'b1;
                  state    <= ST_SHIFT;
               end
            end

            ST_SHIFT: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               sum_sr <= sum_next;
               carry  <= fa_cout;
               if (cnt == LAST) begin
                  // Final bit: publish the result and clear the counter
                  // rather than letting it wrap.
                  cnt      <= '0;
                  bus.Sum  <= sum_next;
                  bus.Cout <= fa_cout;
                  bus.Done <= 1'b1;
                  state    <= ST_DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            ST_DONE: begin
               bus.Done <= 1'b0;
               bus.Busy <= 1'b0;
               state    <= ST_IDLE;
            end

            default: begin
               bus.Done <= 1'b0;
               bus.Busy <= 1'b0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder at WIDTH 8 and 4
module tb_serial_adder;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   serial_adder_if #(.WIDTH(8)) i8 ();
   serial_adder_if #(.WIDTH(4)) i4 ();

   serial_adder #(.WIDTH(8)) dut8 (
      .Clk   (clk),
      .Reset (rst),
      .bus   (i8)
   );

   serial_adder #(.WIDTH(4)) dut4 (
      .Clk   (clk),
      .Reset (rst),
      .bus   (i4)
   );

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [8:0] last8;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One WIDTH=8 addition; with noise, inputs (including Start) are scrambled
   // while busy and Start is re-pulsed with other operands in the Done cycle.
   task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic cin, input bit noise);
      logic [8:0] exp;
      int         lat;
      int         busy_n;
      exp = 9'(a) + 9'(b) + 9'(cin);
      i8.A     = a;
      i8.B     = b;
      i8.Cin   = cin;
      i8.Start = 1'b1;
      @(negedge clk);
      i8.Start = 1'b0;
      lat      = 0;
      busy_n   = 0;
      while (i8.Done !== 1'b1 && lat < 20) begin
         if (i8.Busy === 1'b1) busy_n++;
         if (lat == 3) check({tag, "_hold"}, {i8.Cout, i8.Sum}, last8);
         if (noise) begin
            i8.A     = 8'($urandom);
            i8.B     = 8'($urandom);
            i8.Cin   = 1'($urandom);
            i8.Start = 1'($urandom);
         end
         @(negedge clk);
         lat++;
      end
      if (i8.Busy === 1'b1) busy_n++;
      check({tag, "_latency"}, 64'(lat), 64'd8);
      check({tag, "_busy_cycles"}, 64'(busy_n), 64'd9);
      check({tag, "_result"}, {i8.Cout, i8.Sum}, exp);
      last8 = exp;
      if (noise) begin
         i8.Start = 1'b1;
         i8.A     = ~a;
         i8.B     = ~b;
      end
      @(negedge clk);
      i8.Start = 1'b0;
      check({tag, "_idle_busy"}, i8.Busy, 1'b0);
      check({tag, "_done_pulse"}, i8.Done, 1'b0);
   endtask

   initial begin
      rst      = 1'b1;
      i8.Start = 1'b0; i8.A = '0; i8.B = '0; i8.Cin = 1'b0;
      i4.Start = 1'b0; i4.A = '0; i4.B = '0; i4.Cin = 1'b0;
      last8    = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_busy", i8.Busy, 1'b0);
      check("rst_done", i8.Done, 1'b0);
      check("rst_result", {i8.Cout, i8.Sum}, 9'h000);
      check("rst4_result", {i4.Busy, i4.Done, i4.Cout, i4.Sum}, 7'h00);
      @(negedge clk);

      op8("zero", 8'h00, 8'h00, 1'b0, 1'b0);
      op8("ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
      op8("3c_42", 8'h3C, 8'h42, 1'b0, 1'b0);
      op8("a5_5a", 8'hA5, 8'h5A, 1'b1, 1'b0);
      op8("ignore_start", 8'h9B, 8'h37, 1'b1, 1'b1);

      // Abort mid-operation
      i8.A = 8'h12; i8.B = 8'h34; i8.Cin = 1'b0; i8.Start = 1'b1;
      @(negedge clk);
      i8.Start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", i8.Busy, 1'b0);
      check("abort_result", {i8.Cout, i8.Sum}, 9'h000);
      check("abort_done", i8.Done, 1'b0);
      last8 = '0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("abort_no_done", i8.Done, 1'b0);
      end
      op8("after_abort", 8'h80, 8'h80, 1'b1, 1'b0);

      // Reset wins over a simultaneous Start
      rst = 1'b1; i8.Start = 1'b1; i8.A = 8'h11; i8.B = 8'h22;
      @(negedge clk);
      rst = 1'b0; i8.Start = 1'b0;
      check("rst_start_busy", i8.Busy, 1'b0);
      @(negedge clk);
      check("rst_start_busy2", i8.Busy, 1'b0);
      last8 = '0;

      for (int r = 0; r < 20; r++)
         op8("random", 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);

      // Exhaustive WIDTH=4 sweep with Start held high for back-to-back accepts
      i4.Start = 1'b1;
      for (int k = 0; k < 512; k++) begin
         logic [8:0] kv;
         logic [4:0] exp4;
         int         t;
         kv    = 9'(k);
         i4.A   = kv[3:0];
         i4.B   = kv[7:4];
         i4.Cin = kv[8];
         exp4  = 5'(kv[3:0]) + 5'(kv[7:4]) + 5'(kv[8]);
         t = 0;
         @(negedge clk);
         while (i4.Done !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
         end
         if (t >= 20) check("sweep_timeout", 64'(t), 64'd0);
         check("sweep", {i4.Cout, i4.Sum}, exp4);
      end
      i4.Start = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
